// File: rtl/updown_count_arbiter_pkg.sv
// Shared types for the up/down counter arbiter: FSM state encoding and step-direction constants.
// Pure declarations, no logic, no latency.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_count_arbiter_if.sv
// Requester-side bundle for the shared counter: step requests in, grant/ack/count status out.
// Requesters hold req until ack; the arbiter side owns every output field.
interface updown_count_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);

  logic             clr;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  dir;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             bound;

  modport master (
    output clr, req, dir,
    input  gnt, ack, count, busy, bound
  );

  modport slave (
    input  clr, req, dir,
    output gnt, ack, count, busy, bound
  );

endinterface

// File: rtl/updown_count_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping modulo NREQ.
// Zero latency; the pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   winner
);

  logic [PW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/updown_count_arbiter.sv
// Round-robin sole writer of a shared up/down counter: grant 1 cycle after req, count/ack 1 cycle later,
// one step per 3 cycles; requesters hold req until their one-cycle ack pulse.
module updown_count_arbiter
  import updown_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_count_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_q;
  logic             dir_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             bound_q;

  logic             any;
  logic [PW-1:0]    win;
  logic [WIDTH-1:0] step_val;
  logic             step_bnd;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (any),
    .winner (win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.clr && any) state_nxt = APPLY;
      APPLY:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating mode holds the count at a bound; wrap mode lets the +/-1 roll over naturally.
  always_comb begin
    step_bnd = (dir_q == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);
    if (step_bnd && !WRAP) step_val = count_q;
    else if (dir_q == DIR_UP) step_val = count_q + 1'b1;
    else step_val = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      win_q   <= '0;
      dir_q   <= DIR_DOWN;
      gnt_q   <= '0;
      ack_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      bound_q <= 1'b0;
      busy_q  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (bus.clr) begin
            count_q <= '0;
          end else if (any) begin
            gnt_q <= NREQ'(1) << win;
            win_q <= win;
            dir_q <= bus.dir[win];
          end
        end
        APPLY: begin
          // ack still pulses when clr discards the step, so the requester is never stranded
          gnt_q <= '0;
          ack_q <= gnt_q;
          ptr   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          if (bus.clr) begin
            count_q <= '0;
          end else begin
            count_q <= step_val;
            bound_q <= step_bnd;
          end
        end
        ACK: begin
          if (bus.clr) count_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.bound = bound_q;

endmodule
